// File: rtl/seq_pattern_gen_if.sv
// Handshake and serial-data bundle for seq_pattern_gen.
// The master side (controller or testbench) requests jobs and observes the
// serial stream; the slave side is the pattern generator itself.
interface seq_pattern_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] rpt;
    logic             y;
    logic             y_vld;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pat, rpt,
        input  y, y_vld, busy, done
    );

    modport slave (
        input  start, abort, pat, rpt,
        output y, y_vld, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out on y, MSB first,
// repeated (rpt+1) times back to back, with a start/busy/done handshake.
// Optional feature: define SEQ_GEN_PARITY_EN to append one even-parity bit
// (PAR state) after every repetition of the pattern.
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input logic           clk,
    input logic           rst_n,
    seq_pattern_gen_if.slave bus
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_dec;
    logic             y_q, y_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign idx_dec   = idx_q - IDX_W'(1);

    assign bus.y     = y_q;
    assign bus.y_vld = vld_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // State, captured job and registered outputs; reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            y_q     <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; outputs are computed for the next cycle so y lines up with the bit index.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        y_d     = 1'b0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = SEND;
                    pat_d   = bus.pat;
                    rep_d   = bus.rpt;
                    idx_d   = IDX_MSB;
                    y_d     = bus.pat[PAT_W-1];
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d  = idx_dec;
                    y_d    = pat_q[idx_dec];
                    vld_d  = 1'b1;
                    busy_d = 1'b1;
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    state_d = PAR;
                    y_d     = ^pat_q;
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
`else
                    if (rep_q != '0) begin
                        rep_d  = rep_q - CNT_W'(1);
                        idx_d  = IDX_MSB;
                        y_d    = pat_q[PAT_W-1];
                        vld_d  = 1'b1;
                        busy_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b1;
                    end
`endif
                end
            end

`ifdef SEQ_GEN_PARITY_EN
            PAR: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (rep_q != '0) begin
                    state_d = SEND;
                    rep_d   = rep_q - CNT_W'(1);
                    idx_d   = IDX_MSB;
                    y_d     = pat_q[PAT_W-1];
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed testbench for seq_pattern_gen. Expected streams are hand-written
// for both the default build and the SEQ_GEN_PARITY_EN build.
module tb_seq_pattern_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

`ifdef SEQ_GEN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    seq_pattern_gen_if #(.PAT_W(4), .CNT_W(4)) bus ();

    seq_pattern_gen #(.PAT_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case something hangs
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Pulse start for one cycle; returns at the negedge where the first bit is visible
    task automatic applyStimulus(input logic [3:0] p, input logic [3:0] r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.pat   = p;
        bus.rpt   = r;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Record the stream until busy drops (bounded)
    task automatic collect(input int max_cycles, output int nvld, output logic [127:0] bits,
                           output int ndone, output int done_at, output int last_vld,
                           output bit timed_out);
        bit finished;
        nvld = 0; bits = '0; ndone = 0; done_at = -1; last_vld = -1; finished = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.y_vld) begin
                bits = {bits[126:0], bus.y};
                nvld++;
                last_vld = i;
            end
            if (bus.done) begin
                ndone++;
                done_at = i;
            end
            if (!bus.busy) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        timed_out = !finished;
    endtask

    task automatic test_reset;
        bus.start = 1'($urandom);
        bus.abort = 1'($urandom);
        bus.pat   = 4'($urandom);
        bus.rpt   = 4'($urandom);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.y !== 1'b0)     begin errors++; $display("[TB] FAIL reset_y: got %b expected 0", bus.y); end
        checks++; if (bus.y_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_y_vld: got %b expected 0", bus.y_vld); end
        checks++; if (bus.busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_hold_busy: got %b expected 0", bus.busy); end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int nvld, ndone, done_at, last_vld, det, exp_n, exp_det;
        logic [127:0] bits;
        logic [9:0] exp_bits;
        logic [3:0] w;
        bit to;
        exp_n    = PAR_EN ? 10 : 8;
        exp_det  = PAR_EN ? 2 : 3;
        exp_bits = PAR_EN ? 10'b1010010100 : 10'b0010101010;
        applyStimulus(4'b1010, 4'd1);
        collect(40, nvld, bits, ndone, done_at, last_vld, to);
        checks++; if (to !== 1'b0)    begin errors++; $display("[TB] FAIL basic_timeout: got %b expected 0", to); end
        checks++; if (nvld !== exp_n) begin errors++; $display("[TB] FAIL basic_nvld: got %0d expected %0d", nvld, exp_n); end
        checks++; if (bits[9:0] !== exp_bits) begin errors++; $display("[TB] FAIL basic_bits: got %b expected %b", bits[9:0], exp_bits); end
        checks++; if (ndone !== 1)    begin errors++; $display("[TB] FAIL basic_ndone: got %0d expected 1", ndone); end
        checks++; if (done_at !== last_vld + 1) begin errors++; $display("[TB] FAIL basic_done_pos: got %0d expected %0d", done_at, last_vld + 1); end
        // Overlapping 1010 detector applied to the observed stream
        det = 0; w = '0;
        for (int k = 0; k < nvld; k++) begin
            w = {w[2:0], bits[nvld-1-k]};
            if (k >= 3 && w == 4'b1010) det++;
        end
        checks++; if (det !== exp_det) begin errors++; $display("[TB] FAIL basic_detections: got %0d expected %0d", det, exp_det); end
    endtask

    task automatic test_abort;
        int nvld, ndone, done_at, last_vld, dcount;
        logic [127:0] bits;
        logic [4:0] exp_bits;
        bit to;
        applyStimulus(4'b1100, 4'd0);
        checks++; if (bus.y !== 1'b1 || bus.y_vld !== 1'b1) begin errors++; $display("[TB] FAIL abort_first_bit: got y=%b vld=%b expected y=1 vld=1", bus.y, bus.y_vld); end
        repeat (2) @(negedge clk);
        checks++; if (bus.y !== 1'b0 || bus.y_vld !== 1'b1) begin errors++; $display("[TB] FAIL abort_third_bit: got y=%b vld=%b expected y=0 vld=1", bus.y, bus.y_vld); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++; if (bus.y_vld !== 1'b0) begin errors++; $display("[TB] FAIL abort_vld: got %b expected 0", bus.y_vld); end
        checks++; if (bus.busy !== 1'b0)  begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done) dcount++;
            @(negedge clk);
        end
        checks++; if (dcount !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", dcount); end
        exp_bits = PAR_EN ? 5'b11000 : 5'b01100;
        applyStimulus(4'b1100, 4'd0);
        collect(40, nvld, bits, ndone, done_at, last_vld, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL abort_restart_timeout: got %b expected 0", to); end
        checks++; if (nvld !== (PAR_EN ? 5 : 4)) begin errors++; $display("[TB] FAIL abort_restart_nvld: got %0d expected %0d", nvld, PAR_EN ? 5 : 4); end
        checks++; if (bits[4:0] !== exp_bits) begin errors++; $display("[TB] FAIL abort_restart_bits: got %b expected %b", bits[4:0], exp_bits); end
        checks++; if (ndone !== 1) begin errors++; $display("[TB] FAIL abort_restart_done: got %0d expected 1", ndone); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vld_h, done_h, y_h, exp_vld, exp_done, exp_y;
        int nv;
        exp_vld  = PAR_EN ? 16'h0F9F : 16'h03CF;
        exp_done = PAR_EN ? 16'h1020 : 16'h0410;
        exp_y    = PAR_EN ? 16'h0306 : 16'h0186;
        @(negedge clk);
        bus.start = 1'b1;
        bus.pat   = 4'b0110;
        bus.rpt   = 4'd0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            vld_h[c]  = bus.y_vld;
            done_h[c] = bus.done;
            y_h[c]    = bus.y;
            if (c == 8) bus.start = 1'b0;
        end
        checks++; if (vld_h !== exp_vld)   begin errors++; $display("[TB] FAIL b2b_vld: got %h expected %h", vld_h, exp_vld); end
        checks++; if (done_h !== exp_done) begin errors++; $display("[TB] FAIL b2b_done: got %h expected %h", done_h, exp_done); end
        checks++; if ((y_h & exp_vld) !== exp_y) begin errors++; $display("[TB] FAIL b2b_y: got %h expected %h", y_h & exp_vld, exp_y); end

        // Start pulses and pattern changes during SEND must be ignored
        applyStimulus(4'b0110, 4'd0);
        vld_h = '0; done_h = '0; y_h = '0;
        for (int c = 0; c < 12; c++) begin
            vld_h[c]  = bus.y_vld;
            done_h[c] = bus.done;
            y_h[c]    = bus.y;
            bus.start = (c == 1 || c == 2);
            bus.pat   = (c == 1 || c == 2) ? 4'b1111 : 4'b0110;
            bus.rpt   = (c == 1 || c == 2) ? 4'd3 : 4'd0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        nv = PAR_EN ? 5 : 4;
        checks++; if (vld_h !== ((16'h1 << nv) - 16'h1)) begin errors++; $display("[TB] FAIL ignore_start_vld: got %h expected %h", vld_h, (16'h1 << nv) - 16'h1); end
        checks++; if (done_h !== (16'h1 << nv)) begin errors++; $display("[TB] FAIL ignore_start_done: got %h expected %h", done_h, 16'h1 << nv); end
        checks++; if (y_h[3:0] !== 4'b0110) begin errors++; $display("[TB] FAIL ignore_start_y: got %b expected 0110", y_h[3:0]); end

        // start and abort together in IDLE: abort wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.y_vld !== 1'b0) begin errors++; $display("[TB] FAIL start_abort_idle: got busy=%b vld=%b expected 0 0", bus.busy, bus.y_vld); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL start_abort_idle_2: got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_max_repeat;
        int nvld, ndone, done_at, last_vld;
        logic [127:0] bits;
        bit to;
        applyStimulus(4'b1001, 4'hF);
        collect(200, nvld, bits, ndone, done_at, last_vld, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL maxrep_timeout: got %b expected 0", to); end
        checks++; if (nvld !== (PAR_EN ? 80 : 64)) begin errors++; $display("[TB] FAIL maxrep_nvld: got %0d expected %0d", nvld, PAR_EN ? 80 : 64); end
        checks++; if (ndone !== 1) begin errors++; $display("[TB] FAIL maxrep_done: got %0d expected 1", ndone); end
        checks++; if (done_at !== last_vld + 1) begin errors++; $display("[TB] FAIL maxrep_done_pos: got %0d expected %0d", done_at, last_vld + 1); end
        checks++; if (bits[4:0] !== (PAR_EN ? 5'b10010 : 5'b11001)) begin errors++; $display("[TB] FAIL maxrep_tail: got %b expected %b", bits[4:0], PAR_EN ? 5'b10010 : 5'b11001); end
    endtask

    task automatic test_reset_mid;
        int dcount, bcount;
        applyStimulus(4'b1111, 4'd3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.y_vld !== 1'b0 || bus.busy !== 1'b0 || bus.y !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_outputs: got y=%b vld=%b busy=%b done=%b expected all 0", bus.y, bus.y_vld, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0; bcount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done) dcount++;
            if (bus.busy) bcount++;
        end
        checks++; if (dcount !== 0 || bcount !== 0) begin errors++; $display("[TB] FAIL midreset_quiet: got done=%0d busy=%0d expected 0 0", dcount, bcount); end
    endtask

`ifdef SEQ_GEN_PARITY_EN
    task automatic test_parity;
        int nvld, ndone, done_at, last_vld;
        logic [127:0] bits;
        bit to;
        applyStimulus(4'b1011, 4'd1);
        collect(40, nvld, bits, ndone, done_at, last_vld, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL parity_timeout: got %b expected 0", to); end
        checks++; if (nvld !== 10) begin errors++; $display("[TB] FAIL parity_nvld: got %0d expected 10", nvld); end
        checks++; if (bits[9:0] !== 10'b1011110111) begin errors++; $display("[TB] FAIL parity_bits: got %b expected 1011110111", bits[9:0]); end
        checks++; if (ndone !== 1 || done_at !== last_vld + 1) begin errors++; $display("[TB] FAIL parity_done: got n=%0d at=%0d expected n=1 at=%0d", ndone, done_at, last_vld + 1); end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pat   = '0;
        bus.rpt   = '0;
        $display("[TB] seq_pattern_gen bench start");
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_max_repeat();
        test_reset_mid();
`ifdef SEQ_GEN_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
